// File: rtl/div_pkg.sv
// Shared definitions for the divider front end.
// Holds the controller state encoding, the fill patterns for results that
// bypass the divider, and the width helper for request queue entries.
package div_pkg;

    // Controller states: wait for work, divider busy, result held for consumer.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } div_state_e;

    // Divide by zero: quotient is every bit set, remainder is the dividend.
    localparam logic DZ_QUOTIENT_FILL   = 1'b1;
    localparam logic DZ_FLAG            = 1'b1;
    // Signed overflow (most negative / -1): quotient is the dividend, remainder zero.
    localparam logic OVF_REMAINDER_FILL = 1'b0;

    // A queued request carries the sign bit plus both operands.
    function automatic int entryWidth(input int dataW);
        return 2 * dataW + 1;
    endfunction

endpackage

// File: rtl/div_req_fifo.sv
// Request queue for the divider front end.
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   push_i, pushData_i     write request and entry (taken only when ready_o=1)
//   ready_o                registered "not full" flag, 0 during reset
//   pop_i, popData_o       read request and head entry
//   empty_o                registered "no entries" flag
module div_req_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    output logic             ready_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] popData_o,
    output logic             empty_o
);

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             ready_q;
    logic             doPush;
    logic             doPop;

    // A push is gated only by the registered ready flag, so a pop in the
    // same cycle never frees a slot for a push into a full queue.
    assign doPush    = push_i && ready_q;
    assign doPop     = pop_i && (count_q != '0);
    assign ready_o   = ready_q;
    assign empty_o   = (count_q == '0);
    assign popData_o = mem_q[rdPtr_q];

    always_comb begin
        count_d = count_q;
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Ready is computed from the next count so it is a clean register output.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            count_q <= count_d;
            ready_q <= (count_d != CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

endmodule

// File: rtl/div_frontend.sv
// Front end for an external sequential divider.
// Queues requests, screens out divide-by-zero and signed overflow without
// starting the divider, runs the rest one at a time and holds each result
// until the consumer takes it. Results leave in request order.
// Ports:
//   clk, rst                                     clock, synchronous active-high reset
//   req_valid/req_ready, req_sign,
//   req_dividend, req_divisor                    request handshake and operands
//   res_valid/res_ready, res_quotient,
//   res_remainder, res_dz                        result handshake, values, div-by-zero flag
//   div_en, div_sign, div_dividend, div_divisor  drive the external divider
//   div_done, div_quotient, div_remainder        divider completion and results
module div_frontend #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_sign,
    input  logic [DATA_W-1:0] req_dividend,
    input  logic [DATA_W-1:0] req_divisor,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_quotient,
    output logic [DATA_W-1:0] res_remainder,
    output logic              res_dz,
    output logic              div_en,
    output logic              div_sign,
    output logic [DATA_W-1:0] div_dividend,
    output logic [DATA_W-1:0] div_divisor,
    input  logic              div_done,
    input  logic [DATA_W-1:0] div_quotient,
    input  logic [DATA_W-1:0] div_remainder
);
    import div_pkg::*;

    localparam int                ENTRY_W  = entryWidth(DATA_W);
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    div_state_e        state_q;
    div_state_e        state_d;

    logic              fifoReady;
    logic              fifoEmpty;
    logic              fifoPop;
    logic [ENTRY_W-1:0] fifoData;

    logic              entSign;
    logic [DATA_W-1:0] entDividend;
    logic [DATA_W-1:0] entDivisor;
    logic              entDivZero;
    logic              entOverflow;

    logic              divEn_q,         divEn_d;
    logic              divSign_q,       divSign_d;
    logic [DATA_W-1:0] divDividend_q,   divDividend_d;
    logic [DATA_W-1:0] divDivisor_q,    divDivisor_d;
    logic              resValid_q,      resValid_d;
    logic [DATA_W-1:0] resQuotient_q,   resQuotient_d;
    logic [DATA_W-1:0] resRemainder_q,  resRemainder_d;
    logic              resDz_q,         resDz_d;

    div_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (req_valid),
        .pushData_i ({req_sign, req_dividend, req_divisor}),
        .ready_o    (fifoReady),
        .pop_i      (fifoPop),
        .popData_o  (fifoData),
        .empty_o    (fifoEmpty)
    );

    assign entSign     = fifoData[ENTRY_W-1];
    assign entDividend = fifoData[2*DATA_W-1:DATA_W];
    assign entDivisor  = fifoData[DATA_W-1:0];
    assign entDivZero  = (entDivisor == '0);
    assign entOverflow = entSign && (entDividend == MOST_NEG) && (entDivisor == '1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. Bypass cases skip RUN so the divider is never started for them.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifoEmpty) begin
                    state_d = (entDivZero || entOverflow) ? ST_OUT : ST_RUN;
                end
            end
            ST_RUN: begin
                if (div_done) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next values. Every output is registered below, so nothing on the
    // request side reaches the result ports combinationally. Returning through
    // IDLE after each result guarantees div_en drops between operations.
    always_comb begin
        fifoPop        = 1'b0;
        divEn_d        = divEn_q;
        divSign_d      = divSign_q;
        divDividend_d  = divDividend_q;
        divDivisor_d   = divDivisor_q;
        resValid_d     = resValid_q;
        resQuotient_d  = resQuotient_q;
        resRemainder_d = resRemainder_q;
        resDz_d        = resDz_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifoEmpty) begin
                    fifoPop       = 1'b1;
                    divSign_d     = entSign;
                    divDividend_d = entDividend;
                    divDivisor_d  = entDivisor;
                    if (entDivZero) begin
                        resQuotient_d  = {DATA_W{DZ_QUOTIENT_FILL}};
                        resRemainder_d = entDividend;
                        resDz_d        = DZ_FLAG;
                        resValid_d     = 1'b1;
                    end else if (entOverflow) begin
                        resQuotient_d  = entDividend;
                        resRemainder_d = {DATA_W{OVF_REMAINDER_FILL}};
                        resDz_d        = ~DZ_FLAG;
                        resValid_d     = 1'b1;
                    end else begin
                        divEn_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (div_done) begin
                    divEn_d        = 1'b0;
                    resQuotient_d  = div_quotient;
                    resRemainder_d = div_remainder;
                    resDz_d        = 1'b0;
                    resValid_d     = 1'b1;
                end
            end
            ST_OUT: begin
                if (res_ready) begin
                    resValid_d = 1'b0;
                end
            end
            default: begin
                divEn_d    = 1'b0;
                resValid_d = 1'b0;
            end
        endcase
    end

    // Output registers; reset discards any in-flight or held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            divEn_q        <= 1'b0;
            divSign_q      <= 1'b0;
            divDividend_q  <= '0;
            divDivisor_q   <= '0;
            resValid_q     <= 1'b0;
            resQuotient_q  <= '0;
            resRemainder_q <= '0;
            resDz_q        <= 1'b0;
        end else begin
            divEn_q        <= divEn_d;
            divSign_q      <= divSign_d;
            divDividend_q  <= divDividend_d;
            divDivisor_q   <= divDivisor_d;
            resValid_q     <= resValid_d;
            resQuotient_q  <= resQuotient_d;
            resRemainder_q <= resRemainder_d;
            resDz_q        <= resDz_d;
        end
    end

    assign req_ready     = fifoReady;
    assign res_valid     = resValid_q;
    assign res_quotient  = resQuotient_q;
    assign res_remainder = resRemainder_q;
    assign res_dz        = resDz_q;
    assign div_en        = divEn_q;
    assign div_sign      = divSign_q;
    assign div_dividend  = divDividend_q;
    assign div_divisor   = divDivisor_q;

endmodule

// File: doc/div_frontend.md
DIV_FRONTEND -- requirements
Module: div_frontend

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand/result width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: request queue entries, power of two.
REQ-003 SHALL have port clk  input  1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1: request offered.
REQ-006 SHALL have port req_ready  output  1: queue can accept.
REQ-007 SHALL have port req_sign  input  1: 1 = two's-complement division.
REQ-008 SHALL have ports req_dividend and req_divisor  input  DATA_W each.
REQ-009 SHALL have port res_valid  output  1: result held.
REQ-010 SHALL have port res_ready  input  1: consumer accepts the result.
REQ-011 SHALL have ports res_quotient and res_remainder  output  DATA_W each.
REQ-012 SHALL have port res_dz  output  1: divide-by-zero flag for the held result.
REQ-013 SHALL have port div_en  output  1: drives the downstream div_subshift en input.
REQ-014 SHALL have port div_sign  output  1: drives the divider sign input.
REQ-015 SHALL have ports div_dividend and div_divisor  output  DATA_W each: divider operands.
REQ-016 SHALL have port div_done  input  1: divider result valid.
REQ-017 SHALL have ports div_quotient and div_remainder  input  DATA_W each: divider results.

Function
REQ-018 SHALL accept a request on any rising edge where req_valid=1 and req_ready=1.
REQ-019 SHALL drive req_ready = queue not full, from registered count; no push when full, even if a pop occurs in the same cycle.
REQ-020 SHALL make a push into an empty queue visible to the controller one cycle later.
REQ-021 SHALL implement an FSM with states IDLE, RUN, OUT.
REQ-022 In IDLE with a non-empty queue, SHALL pop one entry and register its operands into div_sign, div_dividend and div_divisor.
REQ-023 On that pop, if divisor=0, SHALL go to OUT with quotient all-ones, remainder=dividend, res_dz=1; div_en SHALL stay 0.
REQ-024 On that pop, if sign=1, dividend is the most negative value and divisor is all-ones, SHALL go to OUT with quotient=dividend, remainder=0, res_dz=0; the divider is not started.
REQ-025 Otherwise, SHALL go to RUN with div_en=1 from the next cycle.
REQ-026 In RUN, SHALL hold div_en=1 and operands stable until div_done=1 is sampled.
REQ-027 On the edge where div_done=1 is sampled, SHALL capture div_quotient and div_remainder into the result registers, set div_en to 0 and set res_dz to 0, then enter OUT.
REQ-028 In OUT, SHALL assert res_valid=1 with the result held stable until res_valid and res_ready are both high on an edge; it SHALL then return to IDLE.
REQ-029 SHALL keep div_en low for at least one cycle between consecutive divider operations, via the IDLE pass.
REQ-030 SHALL allow queue pushes in every FSM state, so requests queue while a division is in flight.
REQ-031 SHALL return results strictly in request order.
REQ-032 SHALL register all outputs; there is no combinational path from a request input to a result output.

Reset
REQ-033 On rst=1, SHALL empty the queue and set the FSM to IDLE on the next edge.
REQ-034 On rst=1, SHALL clear req_ready, res_valid, res_dz, div_en, div_sign and all data outputs to 0 on the next edge.
REQ-035 Reset in RUN or OUT SHALL discard the in-flight result; div_en SHALL be low on the first edge after rst.
REQ-036 SHALL set req_ready to 1 on the first cycle after rst deasserts.

Structure
REQ-037 The FSM state encoding and the bypass-result constants SHALL be defined in the shared package div_pkg.
REQ-038 The request queue SHALL be the sub-module div_req_fifo, with width 2*DATA_W+1 and depth FIFO_DEPTH.
REQ-039 The divider SHALL NOT be instantiated inside div_frontend; it connects externally through the div_* ports.

Verification (DATA_W=4, div_subshift attached)
REQ-040 Bench SHALL cover: unsigned 13/4 -> res_quotient=3, res_remainder=1, res_dz=0.
REQ-041 Bench SHALL cover: signed -7/2 -> res_quotient=4'hD, res_remainder=4'hF.
REQ-042 Bench SHALL cover: 9/0 -> res_quotient=4'hF, res_remainder=9, res_dz=1, with div_en never high.
REQ-043 Bench SHALL cover: signed -8/-1 -> res_quotient=4'h8, res_remainder=0, with the divider not started.
REQ-044 Bench SHALL cover: res_ready=0 and 6 back-to-back requests -> 5 accepted (1 in flight plus 4 queued) and req_ready=0 on the 6th; after releasing res_ready, all 5 results return in order.
REQ-045 Bench SHALL cover: rst pulse while in RUN -> on the next edge div_en=0, res_valid=0 and req_ready=0; a fresh 6/3 request then returns res_quotient=2, res_remainder=0.
